// File: rtl/decoder_fixed_point_pipeline.sv
// Three-stage fully-connected decoder layer: out[j] = b[j] + sum_i z[i]*w[i][j] in sign-magnitude Q4.(BITSIZE-5).
// Optional macro DECODER_RELU_EN forces negative results to zero in the final stage.
module decoder_fixed_point_pipeline #(
   parameter int N_input  = 2,
   parameter int M_output = 9,
   parameter int BITSIZE  = 16
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                in_valid,
   input  logic [N_input*BITSIZE-1:0]          z,
   input  logic [N_input*M_output*BITSIZE-1:0] w,
   input  logic [M_output*BITSIZE-1:0]         b,
   output logic                                out_valid,
   output logic [M_output*BITSIZE-1:0]         out
);
   localparam int FRAC   = BITSIZE - 5;
   localparam int MAG_W  = BITSIZE - 1;
   localparam int PROD_W = 2 * MAG_W;
   localparam int SHR_W  = PROD_W - FRAC;
   localparam int ACC_W  = BITSIZE + 5 + $clog2(N_input + 1);
   localparam int NP     = N_input * M_output;
   localparam logic [ACC_W-1:0] MAG_MAX = {{(ACC_W-MAG_W){1'b0}}, {MAG_W{1'b1}}};

   function automatic logic [ACC_W-1:0] sm_to_tc(input logic [BITSIZE-1:0] v);
      logic [ACC_W-1:0] m;
      m = {{(ACC_W-MAG_W){1'b0}}, v[MAG_W-1:0]};
      return v[BITSIZE-1] ? -m : m;
   endfunction

   // Truncating the shifted magnitude before negation gives rounding toward zero.
   function automatic logic [ACC_W-1:0] mul_tc(input logic [BITSIZE-1:0] a, input logic [BITSIZE-1:0] c);
      logic [PROD_W-1:0] p;
      logic [ACC_W-1:0]  m;
      p = {{MAG_W{1'b0}}, a[MAG_W-1:0]} * {{MAG_W{1'b0}}, c[MAG_W-1:0]};
      m = {{(ACC_W-SHR_W){1'b0}}, p[PROD_W-1:FRAC]};
      return (a[BITSIZE-1] ^ c[BITSIZE-1]) ? -m : m;
   endfunction

   function automatic logic [BITSIZE-1:0] tc_to_sm(input logic [ACC_W-1:0] s);
      logic               neg;
      logic [ACC_W-1:0]   mag;
      logic [BITSIZE-1:0] r;
      neg = s[ACC_W-1];
      mag = neg ? -s : s;
      if (mag > MAG_MAX) begin
         r = {neg, {MAG_W{1'b1}}};
      end else begin
         r = {neg, mag[MAG_W-1:0]};
      end
`ifdef DECODER_RELU_EN
      r = neg ? {BITSIZE{1'b0}} : r;
`endif
      return r;
   endfunction

   logic [ACC_W-1:0]            r_prod [NP];
   logic [ACC_W-1:0]            r_bias [M_output];
   logic [ACC_W-1:0]            r_sum  [M_output];
   logic [M_output*BITSIZE-1:0] r_out;
   logic [2:0]                  r_valid;

   logic [ACC_W-1:0]            w_prod [NP];
   logic [ACC_W-1:0]            w_bias [M_output];
   logic [ACC_W-1:0]            w_sum  [M_output];
   logic [M_output*BITSIZE-1:0] w_res;

   // Stage 1 datapath: products indexed k = j*N_input + i, matching the w bus layout.
   always_comb begin
      w_prod = '{default: '0};
      w_bias = '{default: '0};
      for (int k = 0; k < NP; k++) begin
         w_prod[k] = mul_tc(z[(k % N_input)*BITSIZE +: BITSIZE], w[k*BITSIZE +: BITSIZE]);
      end
      for (int j = 0; j < M_output; j++) begin
         w_bias[j] = sm_to_tc(b[j*BITSIZE +: BITSIZE]);
      end
   end

   // Stage 2 datapath: per-neuron accumulation of bias and products.
   always_comb begin
      logic [ACC_W-1:0] acc;
      acc   = '0;
      w_sum = '{default: '0};
      for (int j = 0; j < M_output; j++) begin
         acc = r_bias[j];
         for (int i = 0; i < N_input; i++) begin
            acc = acc + r_prod[j*N_input + i];
         end
         w_sum[j] = acc;
      end
   end

   // Stage 3 datapath: back to sign-magnitude with saturation.
   always_comb begin
      w_res = '0;
      for (int j = 0; j < M_output; j++) begin
         w_res[j*BITSIZE +: BITSIZE] = tc_to_sm(r_sum[j]);
      end
   end

   // Pipeline registers and valid shift chain.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_prod  <= '{default: '0};
         r_bias  <= '{default: '0};
         r_sum   <= '{default: '0};
         r_out   <= '0;
         r_valid <= 3'b000;
      end else begin
         r_prod  <= w_prod;
         r_bias  <= w_bias;
         r_sum   <= w_sum;
         r_out   <= w_res;
         r_valid <= {r_valid[1:0], in_valid};
      end
   end

   assign out       = r_out;
   assign out_valid = r_valid[2];
endmodule

// File: tb/tb_decoder_fixed_point_pipeline.sv
// Directed self-checking bench for decoder_fixed_point_pipeline (N_input=2, M_output=9, BITSIZE=16).
module tb_decoder_fixed_point_pipeline;
   localparam int N = 2;
   localparam int M = 9;
   localparam int B = 16;
`ifdef DECODER_RELU_EN
   localparam bit RELU = 1'b1;
`else
   localparam bit RELU = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           in_valid = 1'b0;
   logic [N*B-1:0] z = '0;
   logic [N*M*B-1:0] w = '0;
   logic [M*B-1:0] b = '0;
   logic           out_valid;
   logic [M*B-1:0] out;

   int total = 0;
   int bad = 0;

   // z[0]=+1.0, z[1]=-1.0 so out[j] = w[0][j] - w[1][j] + b[j]
   logic [15:0] w0_std [9] = '{16'h0800, 16'h3000, 16'h3800, 16'hB800, 16'hBC00, 16'hB800, 16'h3800, 16'h3000, 16'h0800};
   logic [15:0] w1_std [9] = '{16'h0800, 16'h1800, 16'h3800, 16'h3C00, 16'h3800, 16'h3C00, 16'hB800, 16'h1800, 16'h0800};
   logic [15:0] b_std  [9] = '{16'h8800, 16'h0800, 16'h0800, 16'hB800, 16'h3C00, 16'h3800, 16'hB800, 16'h3C00, 16'h0800};
   logic [15:0] e_std  [9] = '{16'h8800, 16'h2000, 16'h0800, 16'hFFFF, 16'hB800, 16'hBC00, 16'h3800, 16'h5400, 16'h0800};

   decoder_fixed_point_pipeline #(.N_input(N), .M_output(M), .BITSIZE(B)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .z(z), .w(w), .b(b),
      .out_valid(out_valid), .out(out)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] relu(input logic [15:0] e);
      return (RELU && e[15]) ? 16'h0000 : e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_std();
      z = {16'h8800, 16'h0800};
      for (int j = 0; j < M; j++) begin
         w[(j*N)*B +: B]   = w0_std[j];
         w[(j*N+1)*B +: B] = w1_std[j];
         b[j*B +: B]       = b_std[j];
      end
   endtask

   task automatic load_uni(input logic [15:0] z0, input logic [15:0] z1, input logic [15:0] wv, input logic [15:0] bv);
      z = {z1, z0};
      for (int k = 0; k < N*M; k++) w[k*B +: B] = wv;
      for (int j = 0; j < M; j++) b[j*B +: B] = bv;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      load_std();
      in_valid = 1'b1;
      tick();
      tick();
      total++;
      if (out !== '0) begin bad++; $display("FAIL reset_out: got %h want 0", out); end
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      in_valid = 1'b0;
      rst_n = 1'b1;
      tick();
      tick();
      tick();
   endtask

   task automatic test_standard();
      int lat;
      load_std();
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 10) begin
         tick();
         lat++;
      end
      total++;
      if (lat !== 3) begin bad++; $display("FAIL std_latency: got %0d want 3", lat); end
      for (int j = 0; j < M; j++) begin
         total++;
         if (out[j*B +: B] !== relu(e_std[j])) begin
            bad++; $display("FAIL std_out[%0d]: got %h want %h", j, out[j*B +: B], relu(e_std[j]));
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_w [3];
      exp_w[0] = 16'h0000;
      exp_w[1] = 16'h1234;
      exp_w[2] = 16'h7FFF;
      load_std();
      in_valid = 1'b1;
      tick();
      load_uni(16'h8000, 16'h1234, 16'h0800, 16'h0000);
      tick();
      load_uni(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7800);
      tick();
      in_valid = 1'b0;
      for (int s = 0; s < 3; s++) begin
         total++;
         if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d]: got %b want 1", s, out_valid); end
         for (int j = 0; j < M; j++) begin
            logic [15:0] e;
            e = (s == 0) ? relu(e_std[j]) : exp_w[s];
            total++;
            if (out[j*B +: B] !== e) begin
               bad++; $display("FAIL b2b_out[%0d][%0d]: got %h want %h", s, j, out[j*B +: B], e);
            end
         end
         tick();
      end
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_bubble_end: got %b want 0", out_valid); end
   endtask

   task automatic test_neg_zero();
      logic [15:0] tz0 [5] = '{16'h8000, 16'h8000, 16'h8001, 16'h0001, 16'h0C00};
      logic [15:0] tz1 [5] = '{16'h1234, 16'h9234, 16'h0000, 16'h0000, 16'h0000};
      logic [15:0] tw  [5] = '{16'h0800, 16'h0800, 16'h0001, 16'h0801, 16'h0C00};
      logic [15:0] tb  [5] = '{16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h0000};
      logic [15:0] te  [5] = '{16'h1234, 16'h9234, 16'h0000, 16'h0001, 16'h1200};
      for (int t = 0; t < 5; t++) begin
         load_uni(tz0[t], tz1[t], tw[t], tb[t]);
         in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         tick();
         tick();
         total++;
         if (out_valid !== 1'b1) begin bad++; $display("FAIL nz_valid[%0d]: got %b want 1", t, out_valid); end
         for (int j = 0; j < M; j++) begin
            total++;
            if (out[j*B +: B] !== relu(te[t])) begin
               bad++; $display("FAIL nz_out[%0d][%0d]: got %h want %h", t, j, out[j*B +: B], relu(te[t]));
            end
         end
      end
   endtask

   task automatic test_saturation();
      logic [15:0] tz0 [3] = '{16'h7FFF, 16'h7FFF, 16'h0800};
      logic [15:0] tz1 [3] = '{16'h7FFF, 16'h7FFF, 16'h0000};
      logic [15:0] tw  [3] = '{16'h7FFF, 16'hFFFF, 16'h7FFF};
      logic [15:0] tb  [3] = '{16'h7800, 16'hF800, 16'h8001};
      logic [15:0] te  [3] = '{16'h7FFF, 16'hFFFF, 16'h7FFE};
      for (int t = 0; t < 3; t++) begin
         load_uni(tz0[t], tz1[t], tw[t], tb[t]);
         in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         tick();
         tick();
         for (int j = 0; j < M; j++) begin
            total++;
            if (out[j*B +: B] !== relu(te[t])) begin
               bad++; $display("FAIL sat_out[%0d][%0d]: got %h want %h", t, j, out[j*B +: B], relu(te[t]));
            end
         end
      end
   endtask

   task automatic test_reset_midstream();
      load_std();
      in_valid = 1'b1;
      tick();
      load_uni(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7800);
      tick();
      rst_n = 1'b0;
      in_valid = 1'b0;
      load_uni(16'h0000, 16'h0000, 16'h0000, 16'h0000);
      tick();
      total++;
      if (out !== '0) begin bad++; $display("FAIL mid_rst_out: got %h want 0", out); end
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         total++;
         if (out_valid !== 1'b0 || out !== '0) begin
            bad++; $display("FAIL mid_flush[%0d]: got valid=%b out=%h want valid=0 out=0", c, out_valid, out);
         end
      end
      load_std();
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_early_valid: got %b want 0", out_valid); end
      tick();
      total++;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_first_valid: got %b want 1", out_valid); end
      total++;
      if (out[3*B +: B] !== relu(16'hFFFF)) begin
         bad++; $display("FAIL mid_out3: got %h want %h", out[3*B +: B], relu(16'hFFFF));
      end
   endtask

   initial begin
      test_reset();
      test_standard();
      test_back_to_back();
      test_neg_zero();
      test_saturation();
      test_reset_midstream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
